mem_arbiter: RTL

Two-requester arbiter that shares one single-port memory bus between the pipeline's instruction-fetch port and its data (load/store) port. It sits between the CPU core and a unified instruction/data memory with a variable-latency req/ack handshake. It returns per-port ready pulses that the core uses to stall IF or MEM. Data accesses win by default; a streak counter guarantees that fetch cannot starve.

---
 rtl/mem_arbiter_if.sv | 32 +++
 rtl/mem_arbiter.sv | 94 +++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and memory-bus signals shared by the arbiter and its environment
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, bus_ack, bus_rdata,
        output if_ready, if_rdata, d_ready, d_rdata, bus_req, bus_we, bus_addr, bus_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, bus_ack, bus_rdata,
        input  if_ready, if_rdata, d_ready, d_rdata, bus_req, bus_we, bus_addr, bus_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between fetch and data ports, data first with a fetch anti-starvation streak
module mem_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  b
);
    localparam int SW = $clog2(MAX_DATA_STREAK + 1);

    typedef enum logic [1:0] {IDLE, BUS_IF, BUS_D} state_t;

    state_t            state, state_d;
    logic [SW-1:0]     streak, streak_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, if_rdata_q, d_rdata_q;
    logic              we_q, req_q, if_ready_q, d_ready_q;
    logic              elig_if, elig_d, grant_if, grant_d, done_if, done_d;

    assign b.bus_req   = req_q;
    assign b.bus_we    = we_q;
    assign b.bus_addr  = addr_q;
    assign b.bus_wdata = wdata_q;
    assign b.if_ready  = if_ready_q;
    assign b.d_ready   = d_ready_q;
    assign b.if_rdata  = if_rdata_q;
    assign b.d_rdata   = d_rdata_q;

    // arbitration, next state and streak update; a port whose ready is high is masked
    always_comb begin
        elig_if  = b.if_req && !if_ready_q;
        elig_d   = b.d_req && !d_ready_q;
        grant_if = 1'b0;
        grant_d  = 1'b0;
        state_d  = state;
        streak_d = streak;
        done_if  = state == BUS_IF && b.bus_ack;
        done_d   = state == BUS_D && b.bus_ack;
        if (state == IDLE) begin
            grant_if = elig_if && (!elig_d || streak == SW'(MAX_DATA_STREAK));
            grant_d  = elig_d && !grant_if;
            state_d  = grant_if ? BUS_IF : grant_d ? BUS_D : IDLE;
        end else if (b.bus_ack) begin
            state_d = IDLE;
        end
        if (grant_if)
            streak_d = '0;
        else if (grant_d)
            streak_d = !b.if_req ? '0 : streak == SW'(MAX_DATA_STREAK) ? streak : streak + 1'b1;
    end

    // state and streak registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= state_d;
            streak <= streak_d;
        end
    end

    // bus command latch on grant, completion pulses and read-data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if_ready_q <= done_if;
            d_ready_q  <= done_d;
            if (grant_if || grant_d) begin
                req_q  <= 1'b1;
                addr_q <= grant_d ? b.d_addr : b.if_addr;
                we_q   <= grant_d && b.d_we;
            end else if (done_if || done_d) begin
                req_q <= 1'b0;
            end
            if (grant_d)
                wdata_q <= b.d_wdata;
            if (done_if)
                if_rdata_q <= b.bus_rdata;
            if (done_d && !we_q)
                d_rdata_q <= b.bus_rdata;
        end
    end
endmodule
